// File: rtl/riscat_mem_pkg.sv
// Shared types and default widths for the core's unified RAM port arbiter.
// Read-owner encoding used by mem_port_arbiter; no configuration macros live here.
package riscat_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } mem_owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between fetch and load/store for the shared RAM port.
// MEM_ARB_RR_EN selects round-robin on conflicts; otherwise ls has fixed priority.
module mem_arb_select (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic ls_req,
  output logic if_win,
  output logic ls_win
);

`ifdef MEM_ARB_RR_EN
  // last_ls=0 means fetch won most recently, so a conflict goes to ls next
  logic last_ls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ls <= 1'b0;
    end else if (if_win) begin
      last_ls <= 1'b0;
    end else if (ls_win) begin
      last_ls <= 1'b1;
    end
  end

  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (if_req && ls_req) begin
      if (last_ls) begin
        if_win = 1'b1;
      end else begin
        ls_win = 1'b1;
      end
    end else begin
      if_win = if_req;
      ls_win = ls_req;
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign ls_win = ls_req;
  assign if_win = if_req & ~ls_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between fetch and load/store, routing read data back to its owner.
// Define MEM_ARB_RR_EN for round-robin conflict resolution (handled inside mem_arb_select).
module mem_port_arbiter
  import riscat_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic              if_win;
  logic              ls_win;
  mem_owner_e        pend_q;
  mem_owner_e        pend_d;
  logic              drop_q;
  logic              drop_d;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  mem_arb_select u_select (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .ls_req (ls_req),
    .if_win (if_win),
    .ls_win (ls_win)
  );

  assign if_gnt = if_win & ~reset;
  assign ls_gnt = ls_win & ~reset;

  always_comb begin
    ram_addr  = last_addr;
    ram_we    = 1'b0;
    ram_wstrb = '0;
    ram_wdata = '0;
    pend_d    = OWN_NONE;
    if (ls_gnt) begin
      ram_addr = ls_addr;
      if (ls_we) begin
        ram_we    = 1'b1;
        ram_wstrb = ls_wstrb[STRB_W-1:0];
        ram_wdata = ls_wdata;
      end else begin
        pend_d = OWN_LS;
      end
    end else if (if_gnt) begin
      ram_addr = if_addr;
      pend_d   = OWN_IF;
    end
  end

  // A flush kills the fetch response returning now; a fetch granted alongside it is post-flush.
  always_comb begin
    drop_d = drop_q;
    if (if_gnt) begin
      drop_d = 1'b0;
    end else if (if_flush) begin
      drop_d = 1'b1;
    end
  end

  assign if_rvalid = (pend_q == OWN_IF) & ~if_flush & ~drop_q;
  assign ls_rvalid = (pend_q == OWN_LS);
  assign if_rdata  = if_rvalid ? ram_rdata : if_rdata_q;
  assign ls_rdata  = ls_rvalid ? ram_rdata : ls_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= OWN_NONE;
      drop_q     <= 1'b0;
      last_addr  <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      if (if_gnt || ls_gnt) begin
        last_addr <= ram_addr;
      end
      if (if_rvalid) begin
        if_rdata_q <= ram_rdata;
      end
      if (ls_rvalid) begin
        ls_rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a behavioural RAM/owner model.
// Honours MEM_ARB_RR_EN to select the expected arbitration policy.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_wstrb (ram_wstrb),
    .ram_rdata (ram_rdata)
  );

  int checks = 0;
  int failures = 0;

  // Model: who owns the read in flight (0 none, 1 fetch, 2 ls) and the data it will get back
  int          m_pend;
  logic [31:0] m_pend_data;
  logic [31:0] m_if_hold;
  logic [31:0] m_ls_hold;
  logic [31:0] m_last_addr;
  int          m_last_win;
  logic [31:0] mem [logic [31:0]];

  logic e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;
  int   if_gnt_count, ls_gnt_count;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend      = 0;
    m_pend_data = '0;
    m_if_hold   = '0;
    m_ls_hold   = '0;
    m_last_addr = '0;
    m_last_win  = 1;
  endtask

  task automatic check_output();
    logic [31:0] e_addr;
    logic        e_we;
    if (reset) model_reset();
    e_if_gnt = 1'b0;
    e_ls_gnt = 1'b0;
    if (!reset) begin
      if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_win == 2) e_if_gnt = 1'b1;
        else e_ls_gnt = 1'b1;
`else
        e_ls_gnt = 1'b1;
`endif
      end else begin
        e_if_gnt = if_req;
        e_ls_gnt = ls_req;
      end
    end
    e_addr  = e_ls_gnt ? ls_addr : (e_if_gnt ? if_addr : m_last_addr);
    e_we    = e_ls_gnt && ls_we;
    e_if_rv = (m_pend == 1) && !if_flush;
    e_ls_rv = (m_pend == 2);
    check("if_gnt", if_gnt, e_if_gnt);
    check("ls_gnt", ls_gnt, e_ls_gnt);
    check("ram_addr", ram_addr, e_addr);
    check("ram_we", ram_we, e_we);
    check("ram_wstrb", ram_wstrb, e_we ? ls_wstrb : 4'h0);
    if (e_we) check("ram_wdata", ram_wdata, ls_wdata);
    if (reset) check("ram_wdata_rst", ram_wdata, 32'h0);
    check("if_rvalid", if_rvalid, e_if_rv);
    check("if_rdata", if_rdata, e_if_rv ? m_pend_data : m_if_hold);
    check("ls_rvalid", ls_rvalid, e_ls_rv);
    check("ls_rdata", ls_rdata, e_ls_rv ? m_pend_data : m_ls_hold);
    if (if_gnt) if_gnt_count++;
    if (ls_gnt) ls_gnt_count++;
  endtask

  task automatic update_model();
    logic [31:0] w;
    if (reset) begin
      model_reset();
      return;
    end
    if (e_if_rv) m_if_hold = m_pend_data;
    if (e_ls_rv) m_ls_hold = m_pend_data;
    m_pend = 0;
    if (e_ls_gnt) begin
      m_last_addr = ls_addr;
      m_last_win  = 2;
      if (ls_we) begin
        w = mem_read(ls_addr);
        for (int b = 0; b < 4; b++)
          if (ls_wstrb[b]) w[8*b +: 8] = ls_wdata[8*b +: 8];
        mem[ls_addr] = w;
      end else begin
        m_pend      = 2;
        m_pend_data = mem_read(ls_addr);
      end
    end else if (e_if_gnt) begin
      m_last_addr = if_addr;
      m_last_win  = 1;
      m_pend      = 1;
      m_pend_data = mem_read(if_addr);
    end
  endtask

  task automatic sample_cycle();
    @(negedge clk);
    check_output();
  endtask

  task automatic advance_cycle();
    @(posedge clk);
    update_model();
    #1;
    ram_rdata = (m_pend != 0) ? m_pend_data : $urandom;
  endtask

  task automatic run_cycle();
    sample_cycle();
    advance_cycle();
  endtask

  task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic fl,
                                input logic lr, input logic lw, input logic [31:0] la,
                                input logic [31:0] lwd, input logic [3:0] lst);
    if_req   = ir;
    if_addr  = ia;
    if_flush = fl;
    ls_req   = lr;
    ls_we    = lw;
    ls_addr  = la;
    ls_wdata = lwd;
    ls_wstrb = lst;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic        if_pend, ls_pend;
    logic [31:0] ia, la, lwd;
    logic        lw;
    logic [3:0]  lst;

    model_reset();
    mem[32'h100] = 32'h0000_0013;
    mem[32'h104] = 32'h3333_4444;
    mem[32'h108] = 32'hAAAA_0108;
    mem[32'h200] = 32'h1111_2222;
    mem[32'h400] = 32'hBBBB_0400;
    ram_rdata = '0;
    reset = 1'b1;
    apply_stimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    sample_cycle();
    check("rst_gnts", {if_gnt, ls_gnt}, 2'b00);
    advance_cycle();
    reset = 1'b0;
    idle();
    run_cycle();

    // Fetch only
    apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample_cycle();
    check("t1_if_gnt", if_gnt, 1'b1);
    check("t1_ram_addr", ram_addr, 32'h100);
    advance_cycle();
    idle();
    sample_cycle();
    check("t1_if_rvalid", if_rvalid, 1'b1);
    check("t1_if_rdata", if_rdata, 32'h0000_0013);
    check("t1_ls_rvalid", ls_rvalid, 1'b0);
    advance_cycle();

    // Conflict: load at 0x200 versus fetch at 0x104
`ifdef MEM_ARB_RR_EN
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    run_cycle();
    idle();
    run_cycle();
    apply_stimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    sample_cycle();
    check("t2_first", {if_gnt, ls_gnt}, 2'b10);
    advance_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    sample_cycle();
    check("t2_second", {if_gnt, ls_gnt}, 2'b01);
    check("t2_if_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h3333_4444});
    advance_cycle();
    idle();
    sample_cycle();
    check("t2_ls_rdata", {ls_rvalid, ls_rdata}, {1'b1, 32'h1111_2222});
    advance_cycle();
`else
    apply_stimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    sample_cycle();
    check("t2_first", {if_gnt, ls_gnt}, 2'b01);
    advance_cycle();
    apply_stimulus(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample_cycle();
    check("t2_second", {if_gnt, ls_gnt}, 2'b10);
    check("t2_ls_rdata", {ls_rvalid, ls_rdata}, {1'b1, 32'h1111_2222});
    advance_cycle();
    idle();
    sample_cycle();
    check("t2_if_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h3333_4444});
    advance_cycle();
`endif

    // Partial store
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011);
    sample_cycle();
    check("t3_ram_we", ram_we, 1'b1);
    check("t3_ram_wstrb", ram_wstrb, 4'b0011);
    check("t3_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    advance_cycle();
    idle();
    sample_cycle();
    check("t3_no_rvalid", ls_rvalid, 1'b0);
    advance_cycle();

    // Flush alongside a new fetch
    apply_stimulus(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    run_cycle();
    apply_stimulus(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample_cycle();
    check("t4_suppressed", if_rvalid, 1'b0);
    check("t4_if_gnt", if_gnt, 1'b1);
    advance_cycle();
    idle();
    sample_cycle();
    check("t4_delivered", {if_rvalid, if_rdata}, {1'b1, 32'hBBBB_0400});
    advance_cycle();

    // Reset while a fetch response is outstanding
    apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    run_cycle();
    idle();
    reset = 1'b1;
    sample_cycle();
    check("t5_rst_if_rvalid", if_rvalid, 1'b0);
    check("t5_rst_if_rdata", if_rdata, 32'h0);
    check("t5_rst_ram_addr", ram_addr, 32'h0);
    advance_cycle();
    reset = 1'b0;
    sample_cycle();
    check("t5_post_rst_rvalid", if_rvalid, 1'b0);
    advance_cycle();

    // Continuous conflict for 20 cycles
    if_gnt_count = 0;
    ls_gnt_count = 0;
    apply_stimulus(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    for (int i = 0; i < 20; i++) run_cycle();
`ifdef MEM_ARB_RR_EN
    check("t6_if_count", if_gnt_count, 10);
    check("t6_ls_count", ls_gnt_count, 10);
`else
    check("t6_if_count", if_gnt_count, 0);
    check("t6_ls_count", ls_gnt_count, 20);
`endif
    idle();
    run_cycle();

    // Random traffic: requesters hold their payload until the model says they were granted
    if_pend = 1'b0;
    ls_pend = 1'b0;
    ia = '0; la = '0; lwd = '0; lw = 1'b0; lst = '0;
    for (int i = 0; i < 500; i++) begin
      if (!if_pend && ($urandom % 2 == 0)) begin
        if_pend = 1'b1;
        ia = 32'h1000 + ($urandom_range(0, 15) << 2);
      end
      if (!ls_pend && ($urandom % 2 == 0)) begin
        ls_pend = 1'b1;
        la  = 32'h1000 + ($urandom_range(0, 15) << 2);
        lw  = ($urandom % 3 == 0);
        lwd = $urandom;
        lst = 4'($urandom);
      end
      apply_stimulus(if_pend, ia, ($urandom % 8 == 0), ls_pend, lw, la, lwd, lst);
      reset = ($urandom % 100 == 0);
      run_cycle();
      if (e_if_gnt) if_pend = 1'b0;
      if (e_ls_gnt) ls_pend = 1'b0;
    end
    reset = 1'b0;
    idle();
    run_cycle();
    run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
